// File: rtl/trigger_generator.sv
// Logic-analyzer trigger source: N-th masked level/edge match of i_data fires o_trigger.
// Latency: sample before edge k matched at edge k; all outputs registered (1 cycle).
// Backpressure: none; o_trigger holds high until i_arm, i_disarm or reset.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module trigger_generator #(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_arm,
    input  logic                   i_disarm,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [DATA_WIDTH-1:0]  i_value,
    input  logic [DATA_WIDTH-1:0]  i_mask,
    input  logic [DATA_WIDTH-1:0]  i_edge_mask,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic                   o_trigger,
    output logic                   o_armed,
    output logic [COUNT_WIDTH-1:0] o_hits
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [COUNT_WIDTH-1:0] hits_nxt;
    logic [COUNT_WIDTH-1:0] hits_inc;
    logic                   load_cfg;

    logic [DATA_WIDTH-1:0]  cfg_value;
    logic [DATA_WIDTH-1:0]  cfg_mask;
    logic [DATA_WIDTH-1:0]  cfg_edge;
    logic [COUNT_WIDTH-1:0] cfg_count;

    logic [DATA_WIDTH-1:0]  prev_data;
    logic                   prev_valid;

    logic [DATA_WIDTH-1:0]  lvl_bits;
    logic [DATA_WIDTH-1:0]  edg_bits;
    logic                   level_ok;
    logic                   edge_ok;
    logic                   match;

    // Matching only ever looks at the shadow copy, never the live config inputs.
    assign lvl_bits = cfg_mask & ~cfg_edge;
    assign edg_bits = cfg_mask & cfg_edge;
    assign level_ok = (((i_data ^ cfg_value) & lvl_bits) == '0);
    assign edge_ok  = (edg_bits == '0) ||
                      (prev_valid &&
                       (((i_data ^ cfg_value) & edg_bits) == '0) &&
                       (((prev_data ^ cfg_value) & edg_bits) == edg_bits));
    assign match    = level_ok && edge_ok;
    assign hits_inc = o_hits + 1'b1;

    always_comb begin
        state_nxt = state;
        hits_nxt  = o_hits;
        load_cfg  = 1'b0;
        if (i_disarm) begin
            state_nxt = IDLE;
            hits_nxt  = '0;
        end else if (i_arm) begin
            state_nxt = ARMED;
            hits_nxt  = '0;
            load_cfg  = 1'b1;
        end else begin
            case (state)
                ARMED: begin
                    if (match) begin
                        hits_nxt = hits_inc;
                        if (hits_inc == cfg_count) begin
                            state_nxt = FIRED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            o_hits    <= '0;
            o_trigger <= 1'b0;
            o_armed   <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_hits    <= hits_nxt;
            o_trigger <= (state_nxt == FIRED);
            o_armed   <= (state_nxt == ARMED);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_value <= '0;
            cfg_mask  <= '0;
            cfg_edge  <= '0;
            cfg_count <= '0;
        end else if (load_cfg) begin
            cfg_value <= i_value;
            cfg_mask  <= i_mask;
            cfg_edge  <= i_edge_mask;
            cfg_count <= (i_count == '0) ? COUNT_WIDTH'(1) : i_count;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_data  <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_data  <= i_data;
            prev_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trigger_generator.sv
// Directed bench for trigger_generator: per-cycle expected {trigger, armed, hits}
// is queued when the stimulus is driven and checked after the sampling edge.
module tb_trigger_generator;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_arm;
    logic          i_disarm;
    logic [DW-1:0] i_data;
    logic [DW-1:0] i_value;
    logic [DW-1:0] i_mask;
    logic [DW-1:0] i_edge_mask;
    logic [CW-1:0] i_count;
    logic          o_trigger;
    logic          o_armed;
    logic [CW-1:0] o_hits;

    int compared   = 0;
    int mismatched = 0;

    logic [CW+1:0] sb_q[$];

    trigger_generator #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_arm       (i_arm),
        .i_disarm    (i_disarm),
        .i_data      (i_data),
        .i_value     (i_value),
        .i_mask      (i_mask),
        .i_edge_mask (i_edge_mask),
        .i_count     (i_count),
        .o_trigger   (o_trigger),
        .o_armed     (o_armed),
        .o_hits      (o_hits)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [CW+1:0] exp);
        logic [CW+1:0] obs;
        obs = {o_trigger, o_armed, o_hits};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed trig=%b armed=%b hits=%0d, expected trig=%b armed=%b hits=%0d",
                   tag, obs[CW+1], obs[CW], obs[CW-1:0], exp[CW+1], exp[CW], exp[CW-1:0]);
        end
    endtask

    task automatic set_cfg(input logic [DW-1:0] v, input logic [DW-1:0] m,
                           input logic [DW-1:0] e, input logic [CW-1:0] c);
        i_value     = v;
        i_mask      = m;
        i_edge_mask = e;
        i_count     = c;
    endtask

    // One cycle: drive, queue expectation, sample #1 after the edge, pop and compare.
    task automatic step(input string tag, input logic [DW-1:0] d, input logic arm,
                        input logic disarm, input logic trig, input logic armed,
                        input logic [CW-1:0] hits);
        logic [CW+1:0] exp;
        @(negedge clk);
        i_data   = d;
        i_arm    = arm;
        i_disarm = disarm;
        sb_q.push_back({trig, armed, hits});
        @(posedge clk);
        #1;
        i_arm    = 1'b0;
        i_disarm = 1'b0;
        if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = sb_q.pop_front();
            check(tag, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        i_arm    = 1'b0;
        i_disarm = 1'b0;
        i_data   = '0;
        set_cfg(8'h00, 8'h00, 8'h00, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {1'b0, 1'b0, 8'd0});
        @(negedge clk);
        reset = 1'b0;

        // Idle: matching data does nothing without arming
        step("idle_no_fire", 8'h00, 0, 0, 0, 0, 8'd0);

        // Level match, count 1
        set_cfg(8'hA5, 8'hFF, 8'h00, 8'd1);
        step("lvl_arm",    8'h00, 1, 0, 0, 1, 8'd0);
        step("lvl_s0",     8'h00, 0, 0, 0, 1, 8'd0);
        step("lvl_s1",     8'h00, 0, 0, 0, 1, 8'd0);
        step("lvl_fire",   8'hA5, 0, 0, 1, 0, 8'd1);
        step("lvl_hold",   8'h00, 0, 0, 1, 0, 8'd1);
        step("lvl_hold2",  8'hA5, 0, 0, 1, 0, 8'd1);

        // Don't-care bits and count 3; re-arm from FIRED drops trigger
        set_cfg(8'h03, 8'h0F, 8'h00, 8'd3);
        step("dc_arm",     8'h03, 1, 0, 0, 1, 8'd0);
        step("dc_13",      8'h13, 0, 0, 0, 1, 8'd1);
        step("dc_00a",     8'h00, 0, 0, 0, 1, 8'd1);
        step("dc_F3",      8'hF3, 0, 0, 0, 1, 8'd2);
        step("dc_00b",     8'h00, 0, 0, 0, 1, 8'd2);
        step("dc_fire",    8'h23, 0, 0, 1, 0, 8'd3);

        // Edge detect on bit0: steady 1 never counts, only 0->1
        set_cfg(8'h01, 8'h01, 8'h01, 8'd1);
        step("edge_arm",   8'h01, 1, 0, 0, 1, 8'd0);
        step("edge_1a",    8'h01, 0, 0, 0, 1, 8'd0);
        step("edge_1b",    8'h01, 0, 0, 0, 1, 8'd0);
        step("edge_0",     8'h00, 0, 0, 0, 1, 8'd0);
        step("edge_rise",  8'h01, 0, 0, 1, 0, 8'd1);

        // Disarm beats simultaneous arm; later match does not fire
        set_cfg(8'hA5, 8'hFF, 8'h00, 8'd1);
        step("prio_both",  8'h00, 1, 1, 0, 0, 8'd0);
        step("prio_idle",  8'hA5, 0, 0, 0, 0, 8'd0);
        step("prio_idle2", 8'hA5, 0, 0, 0, 0, 8'd0);

        // Config isolation: live value change while armed is ignored
        set_cfg(8'h5A, 8'hFF, 8'h00, 8'd2);
        step("iso_arm",    8'h00, 1, 0, 0, 1, 8'd0);
        set_cfg(8'h77, 8'hFF, 8'h00, 8'd1);
        step("iso_5A",     8'h5A, 0, 0, 0, 1, 8'd1);
        step("iso_77",     8'h77, 0, 0, 0, 1, 8'd1);
        step("iso_fire",   8'h5A, 0, 0, 1, 0, 8'd2);

        // Re-arm with count 0 acts as count 1; arm-cycle sample not counted
        set_cfg(8'h77, 8'hFF, 8'h00, 8'd0);
        step("c0_arm",     8'h77, 1, 0, 0, 1, 8'd0);
        step("c0_fire",    8'h77, 0, 0, 1, 0, 8'd1);

        // Mask 0 matches every cycle; disarm from ARMED clears hits
        set_cfg(8'h00, 8'h00, 8'h00, 8'd4);
        step("m0_arm",     8'h12, 1, 0, 0, 1, 8'd0);
        step("m0_h1",      8'h34, 0, 0, 0, 1, 8'd1);
        step("m0_h2",      8'h56, 0, 0, 0, 1, 8'd2);
        step("m0_disarm",  8'h78, 0, 1, 0, 0, 8'd0);
        step("m0_rearm",   8'h9A, 1, 0, 0, 1, 8'd0);
        step("m0_r1",      8'h00, 0, 0, 0, 1, 8'd1);
        step("m0_r2",      8'h00, 0, 0, 0, 1, 8'd2);
        step("m0_r3",      8'h00, 0, 0, 0, 1, 8'd3);
        step("m0_fire",    8'h00, 0, 0, 1, 0, 8'd4);

        // Async reset mid-cycle while FIRED
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst", {1'b0, 1'b0, 8'd0});
        @(posedge clk);
        #1;
        check("rst_held", {1'b0, 1'b0, 8'd0});
        @(negedge clk);
        reset = 1'b0;
        step("post_rst",   8'h00, 0, 0, 0, 0, 8'd0);

        // Shadow config was cleared by reset; fresh arm still works
        set_cfg(8'hC3, 8'hFF, 8'h00, 8'd1);
        step("post_arm",   8'h00, 1, 0, 0, 1, 8'd0);
        step("post_fire",  8'hC3, 0, 0, 1, 0, 8'd1);

        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
